// File: rtl/uart_hex_streamer.sv
// Renders binary words as uppercase ASCII hex (MSB nibble first, optional CR LF)
// into a byte FIFO that drains into a uart_tx-style sink via a write-pulse/ready handshake.
module uart_hex_streamer #(
  parameter int DATA_W      = 8,
  parameter bit APPEND_CRLF = 1'b1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_write,
  input  logic                        tx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);
  localparam int NIB = DATA_W / 4;
  localparam int CW  = $clog2(NIB) + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_NIB   = CW'(NIB - 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {F_IDLE, F_DIGIT, F_CR, F_LF, F_DONE} fmt_state_t;
  typedef enum logic [1:0] {D_IDLE, D_WRITE, D_HOLD} drain_state_t;

  fmt_state_t        fmt_state, fmt_next;
  drain_state_t      d_state, d_next;
  logic [DATA_W-1:0] shift;
  logic [CW-1:0]     cnt;
  logic              push, pop, accept, full, empty, hold_cnt;
  logic [7:0]        push_char;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign full     = (fifo_level == FULL_LEVEL);
  assign empty    = (fifo_level == '0);
  assign in_ready = rst_n && (fmt_state == F_IDLE);
  assign accept   = in_valid && in_ready;
  assign tx_write = (d_state == D_WRITE);
  assign busy     = (fmt_state != F_IDLE) || !empty || (d_state != D_IDLE);

  // Formatter: one character per cycle while the FIFO has room; F_DONE is the
  // single turnaround cycle before the next word may be accepted.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    fmt_next  = fmt_state;
    push      = 1'b0;
    push_char = 8'h00;
    case (fmt_state)
      F_IDLE: if (accept) fmt_next = F_DIGIT;
      F_DIGIT: if (!full) begin
        push      = 1'b1;
        push_char = hex_char(shift[DATA_W-1 -: 4]);
        if (cnt == LAST_NIB) fmt_next = APPEND_CRLF ? F_CR : F_DONE;
      end
      F_CR: if (!full) begin
        push      = 1'b1;
        push_char = 8'h0D;
        fmt_next  = F_LF;
      end
      F_LF: if (!full) begin
        push      = 1'b1;
        push_char = 8'h0A;
        fmt_next  = F_DONE;
      end
      F_DONE:  fmt_next = F_IDLE;
      default: fmt_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      fmt_state <= F_IDLE;
      shift     <= '0;
      cnt       <= '0;
    end else begin
      fmt_state <= fmt_next;
      if (accept) begin
        shift <= in_data;
        cnt   <= '0;
      end else if (push && (fmt_state == F_DIGIT)) begin
        shift <= shift << 4;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_char;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  // Drain: pop, one-cycle strobe, then two cycles ignoring tx_ready while the
  // transmitter's ready drop propagates back.
  always_comb begin
    d_next = d_state;
    pop    = 1'b0;
    case (d_state)
      D_IDLE: if (!empty && tx_ready) begin
        pop    = 1'b1;
        d_next = D_WRITE;
      end
      D_WRITE: d_next = D_HOLD;
      D_HOLD:  if (hold_cnt) d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_state  <= D_IDLE;
      hold_cnt <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      d_state  <= d_next;
      hold_cnt <= (d_state == D_HOLD) ? ~hold_cnt : 1'b0;
      if (pop) tx_data <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_uart_hex_streamer.sv
// Directed bench for uart_hex_streamer: three instances cover 8-bit/CRLF, 16-bit/no-CRLF
// and a 4-deep FIFO; expected character streams are hand-written constants.
module tb_uart_hex_streamer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: DATA_W=8, CRLF, depth 16
  logic [7:0] in_data_a = '0;
  logic       in_valid_a = 1'b0, in_ready_a, tx_write_a, tx_ready_a, busy_a;
  logic [7:0] tx_data_a;
  logic [4:0] fifo_level_a;
  logic       ready_cmd_a = 1'b1, slow_a = 1'b0;
  int         hold_a = 0;

  // Instance B: DATA_W=16, no CRLF, depth 16
  logic [15:0] in_data_b = '0;
  logic        in_valid_b = 1'b0, in_ready_b, tx_write_b, busy_b;
  logic        tx_ready_b = 1'b1;
  logic [7:0]  tx_data_b;
  logic [4:0]  fifo_level_b;

  // Instance C: DATA_W=8, CRLF, depth 4
  logic [7:0] in_data_c = '0;
  logic       in_valid_c = 1'b0, in_ready_c, tx_write_c, busy_c;
  logic       tx_ready_c = 1'b0;
  logic [7:0] tx_data_c;
  logic [2:0] fifo_level_c;

  uart_hex_streamer #(.DATA_W(8), .APPEND_CRLF(1'b1), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .tx_data(tx_data_a), .tx_write(tx_write_a),
    .tx_ready(tx_ready_a), .fifo_level(fifo_level_a), .busy(busy_a));

  uart_hex_streamer #(.DATA_W(16), .APPEND_CRLF(1'b0), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .tx_data(tx_data_b), .tx_write(tx_write_b),
    .tx_ready(tx_ready_b), .fifo_level(fifo_level_b), .busy(busy_b));

  uart_hex_streamer #(.DATA_W(8), .APPEND_CRLF(1'b1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_c), .in_valid(in_valid_c),
    .in_ready(in_ready_c), .tx_data(tx_data_c), .tx_write(tx_write_c),
    .tx_ready(tx_ready_c), .fifo_level(fifo_level_c), .busy(busy_c));

  // Slow sink for A: ready drops for 160 cycles after every write strobe.
  always @(posedge clk) begin
    if (tx_write_a)      hold_a <= 160;
    else if (hold_a > 0) hold_a <= hold_a - 1;
  end
  assign tx_ready_a = slow_a ? (hold_a == 0) : ready_cmd_a;

  // Byte capture, sampled on the falling edge.
  logic [7:0] q_a[$], q_b[$], q_c[$];
  int         t_a[$];
  always @(negedge clk) begin
    if (tx_write_a) begin
      q_a.push_back(tx_data_a);
      t_a.push_back(cyc);
    end
    if (tx_write_b) q_b.push_back(tx_data_b);
    if (tx_write_c) q_c.push_back(tx_data_c);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  function automatic logic [7:0] qbyte(input int sel, input int idx);
    if (idx >= qsize(sel)) return 8'hxx;
    case (sel)
      0:       return q_a[idx];
      1:       return q_b[idx];
      default: return q_c[idx];
    endcase
  endfunction

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return in_ready_a;
      1:       return in_ready_b;
      default: return in_ready_c;
    endcase
  endfunction

  task automatic send(input int sel, input logic [15:0] w, output int acc);
    bit done = 1'b0;
    acc = -1;
    case (sel)
      0:       begin in_data_a = w[7:0]; in_valid_a = 1'b1; end
      1:       begin in_data_b = w;      in_valid_b = 1'b1; end
      default: begin in_data_c = w[7:0]; in_valid_c = 1'b1; end
    endcase
    for (int k = 0; k < 400 && !done; k++) begin
      done = rdy(sel);
      acc  = cyc;
      tick();
    end
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    in_valid_c = 1'b0;
    check($sformatf("accept dut%0d word %0h", sel, w), {31'd0, done}, 32'd1);
  endtask

  task automatic wait_bytes(input int sel, input int n, input int budget);
    int i = 0;
    while (qsize(sel) < n && i < budget) begin
      tick();
      i++;
    end
    check($sformatf("byte count dut%0d", sel), qsize(sel), n);
  endtask

  typedef struct {
    logic [7:0]  word;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int acc, acc0, acc1, acc2, base, low, bad;
    logic [95:0] b2b_exp;
    logic [63:0] c_exp;
    logic [31:0] slow_exp;
    logic [31:0] b_exp;

    vecs[0] = '{8'h1F, 32'h31_46_0D_0A};
    vecs[1] = '{8'h00, 32'h30_30_0D_0A};
    vecs[2] = '{8'hFF, 32'h46_46_0D_0A};
    vecs[3] = '{8'h9A, 32'h39_41_0D_0A};
    vecs[4] = '{8'hA5, 32'h41_35_0D_0A};
    vecs[5] = '{8'h7E, 32'h37_45_0D_0A};
    b2b_exp  = 96'h30300D0A_46460D0A_39410D0A;
    c_exp    = 64'h31320D0A_33340D0A;
    slow_exp = 32'h43_33_0D_0A;
    b_exp    = 32'h41_30_35_43;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst in_ready_a", {31'd0, in_ready_a}, 0);
    check("rst tx_write_a", {31'd0, tx_write_a}, 0);
    check("rst tx_data_a", tx_data_a, 0);
    check("rst level_a", fifo_level_a, 0);
    check("rst busy_a", {31'd0, busy_a}, 0);
    check("rst level_c", fifo_level_c, 0);
    rst_n = 1'b1;
    #1;
    check("post-rst in_ready_a", {31'd0, in_ready_a}, 1);
    check("post-rst in_ready_b", {31'd0, in_ready_b}, 1);

    // Table: one word at a time, tx_ready high
    for (int v = 0; v < 6; v++) begin
      base = q_a.size();
      send(0, {8'h00, vecs[v].word}, acc);
      wait_bytes(0, base + 4, 100);
      for (int k = 0; k < 4; k++)
        check($sformatf("vec%0d byte%0d", v, k), qbyte(0, base + k), vecs[v].exp[8*(3-k) +: 8]);
      for (int k = 1; k < 4; k++)
        if (base + k < t_a.size())
          check($sformatf("vec%0d write gap%0d", v, k), t_a[base+k] - t_a[base+k-1], 4);
      repeat (4) tick();
      check($sformatf("vec%0d busy idle", v), {31'd0, busy_a}, 0);
      check($sformatf("vec%0d level empty", v), fifo_level_a, 0);
    end

    // Back-to-back words: accepts spaced NIB+2 digits/CRLF + 1 turnaround + accept cycle
    base = q_a.size();
    send(0, 16'h0000, acc0);
    send(0, 16'h00FF, acc1);
    send(0, 16'h009A, acc2);
    check("b2b accept spacing 1", acc1 - acc0, 6);
    check("b2b accept spacing 2", acc2 - acc1, 6);
    wait_bytes(0, base + 12, 200);
    for (int k = 0; k < 12; k++)
      check($sformatf("b2b byte%0d", k), qbyte(0, base + k), b2b_exp[8*(11-k) +: 8]);
    repeat (6) tick();

    // Slow sink on A
    base   = q_a.size();
    slow_a = 1'b1;
    send(0, 16'h00C3, acc);
    wait_bytes(0, base + 4, 1000);
    for (int k = 0; k < 4; k++)
      check($sformatf("slow byte%0d", k), qbyte(0, base + k), slow_exp[8*(3-k) +: 8]);
    for (int k = 1; k < 4; k++)
      if (base + k < t_a.size())
        check($sformatf("slow gap%0d >= 160", k), {31'd0, (t_a[base+k] - t_a[base+k-1]) >= 160}, 1);
    repeat (5) tick();
    check("tx_data holds last", tx_data_a, 8'h0A);
    repeat (170) tick();
    slow_a = 1'b0;

    // 16-bit, no CRLF
    send(1, 16'hA05C, acc);
    low = 0;
    while (!in_ready_b && low < 20) begin
      low++;
      tick();
    end
    check("b in_ready low cycles", low, 5);
    wait_bytes(1, 4, 100);
    for (int k = 0; k < 4; k++)
      check($sformatf("b byte%0d", k), qbyte(1, k), b_exp[8*(3-k) +: 8]);

    // Depth-4 FIFO with stalled sink
    send(2, 16'h0012, acc);
    send(2, 16'h0034, acc);
    repeat (10) tick();
    check("c level full", fifo_level_c, 4);
    check("c in_ready stalled", {31'd0, in_ready_c}, 0);
    check("c busy", {31'd0, busy_c}, 1);
    check("c no writes", q_c.size(), 0);
    bad = 0;
    repeat (20) begin
      tick();
      if (in_ready_c || fifo_level_c != 3'd4) bad++;
    end
    check("c stall stable", bad, 0);
    tx_ready_c = 1'b1;
    wait_bytes(2, 8, 200);
    for (int k = 0; k < 8; k++)
      check($sformatf("c byte%0d", k), qbyte(2, k), c_exp[8*(7-k) +: 8]);
    repeat (30) tick();
    check("c no duplicates", q_c.size(), 8);
    check("c level drained", fifo_level_c, 0);
    check("c busy idle", {31'd0, busy_c}, 0);

    // Reset mid-message on A
    base = q_a.size();
    send(0, 16'h001F, acc);
    wait_bytes(0, base + 2, 100);
    check("pre-reset level", fifo_level_a, 2);
    rst_n = 1'b0;
    tick();
    check("mid-rst tx_write", {31'd0, tx_write_a}, 0);
    check("mid-rst level", fifo_level_a, 0);
    check("mid-rst in_ready", {31'd0, in_ready_a}, 0);
    check("mid-rst tx_data", tx_data_a, 0);
    rst_n = 1'b1;
    #1;
    check("after-rst in_ready", {31'd0, in_ready_a}, 1);
    repeat (30) tick();
    check("no stale bytes", q_a.size(), base + 2);
    check("after-rst busy", {31'd0, busy_a}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
